// File: rtl/axi_ax_rr_sched.sv
// Round-robin scheduler that shares one AXI AR/AW channel among NUM_REQ requesters,
// tags the ID with the winner index and caps in-flight transactions at MAX_TXNS.
module axi_ax_rr_sched #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int IDX_WIDTH  = $clog2(NUM_REQ),
   parameter int MAX_TXNS   = 8,
   parameter int CNT_WIDTH  = $clog2(MAX_TXNS + 1)
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NUM_REQ-1:0]               in_valid_i,
   output logic [NUM_REQ-1:0]               in_ready_o,
   input  logic [NUM_REQ*ID_WIDTH-1:0]      in_id_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    in_addr_i,
   input  logic [NUM_REQ*8-1:0]             in_len_i,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic [ID_WIDTH+IDX_WIDTH-1:0]    out_id_o,
   output logic [ADDR_WIDTH-1:0]            out_addr_o,
   output logic [7:0]                       out_len_o,
   input  logic                             rsp_done_i,
   output logic [CNT_WIDTH-1:0]             outstanding_o,
   output logic                             full_o
);

   logic [IDX_WIDTH-1:0] ptr;
   logic [IDX_WIDTH-1:0] cand;
   logic [IDX_WIDTH-1:0] next_ptr;
   logic [IDX_WIDTH:0]   pos;
   logic [IDX_WIDTH:0]   ptr_inc;
   logic                 found;
   logic                 slot_free;
   logic                 can_accept;
   logic                 accept;
   logic                 dec;

   assign slot_free  = !out_valid_o || out_ready_i;
   // The limit depends only on the registered count, so rsp_done_i never reaches a ready.
   assign can_accept = slot_free && (outstanding_o < CNT_WIDTH'(MAX_TXNS));
   assign full_o     = (outstanding_o == CNT_WIDTH'(MAX_TXNS));
   assign dec        = rsp_done_i && (outstanding_o != '0);

   // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      found      = 1'b0;
      cand       = '0;
      pos        = '0;
      in_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos = {1'b0, ptr} + (IDX_WIDTH+1)'(i);
         if (pos >= (IDX_WIDTH+1)'(NUM_REQ)) pos = pos - (IDX_WIDTH+1)'(NUM_REQ);
         if (!found && in_valid_i[pos[IDX_WIDTH-1:0]]) begin
            found = 1'b1;
            cand  = pos[IDX_WIDTH-1:0];
         end
      end
      if (found) in_ready_o[cand] = can_accept && !rst_i;
   end

   assign accept = found && can_accept && !rst_i;

   always_comb begin
      ptr_inc  = {1'b0, cand} + (IDX_WIDTH+1)'(1);
      next_ptr = ptr_inc[IDX_WIDTH-1:0];
      if (ptr_inc == (IDX_WIDTH+1)'(NUM_REQ)) next_ptr = '0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr           <= '0;
         out_valid_o   <= 1'b0;
         out_id_o      <= '0;
         out_addr_o    <= '0;
         out_len_o     <= '0;
         outstanding_o <= '0;
      end else begin
         if (accept) begin
            out_valid_o <= 1'b1;
            out_id_o    <= {cand, in_id_i[cand*ID_WIDTH +: ID_WIDTH]};
            out_addr_o  <= in_addr_i[cand*ADDR_WIDTH +: ADDR_WIDTH];
            out_len_o   <= in_len_i[cand*8 +: 8];
            ptr         <= next_ptr;
         end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
         end

         unique case ({accept, dec})
            2'b10:   outstanding_o <= outstanding_o + CNT_WIDTH'(1);
            2'b01:   outstanding_o <= outstanding_o - CNT_WIDTH'(1);
            default: outstanding_o <= outstanding_o;
         endcase
      end
   end

`ifndef SYNTHESIS
   rsp_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
      rsp_done_i |-> outstanding_o != '0)
      else $error("rsp_done_i with no outstanding transaction");

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_req_hold
      req_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
         in_valid_i[k] && !in_ready_o[k] |=> in_valid_i[k])
         else $error("requester %0d dropped valid before ready", k);
   end
`endif

endmodule

// File: doc/axi_ax_rr_sched.md
Name: axi_ax_rr_sched

Overview:
- Round-robin scheduler that shares one AXI address channel (AR or AW) among NUM_REQ requesters.
- Tags each granted request with the requester index in the upper ID bits.
- Caps in-flight transactions at MAX_TXNS and frees a slot on each response-completion pulse.
- Sits in front of an axi_multicut chain. Its registered output stage acts as the first cut on the address path.

Parameters:
- NUM_REQ, 4, number of requesters; must be >= 2.
- ADDR_WIDTH, 32, address width.
- ID_WIDTH, 4, requester-side ID width.
- IDX_WIDTH, $clog2(NUM_REQ), derived; number of index bits prepended to the ID.
- MAX_TXNS, 8, maximum in-flight transactions; must be >= 1.
- CNT_WIDTH, $clog2(MAX_TXNS+1), derived; width of the outstanding counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- in_valid_i  in  NUM_REQ  per-requester AX valid.
- in_ready_o  out  NUM_REQ  per-requester AX ready.
- in_id_i  in  NUM_REQ*ID_WIDTH  packed IDs; requester k occupies bits [k*ID_WIDTH +: ID_WIDTH].
- in_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses.
- in_len_i  in  NUM_REQ*8  packed burst lengths.
- out_valid_o  out  1  AX valid toward the cut chain.
- out_ready_i  in  1  AX ready from the cut chain.
- out_id_o  out  ID_WIDTH+IDX_WIDTH  {granted index, requester ID}.
- out_addr_o  out  ADDR_WIDTH  address of the granted request.
- out_len_o  out  8  burst length of the granted request.
- rsp_done_i  in  1  one-cycle pulse per completed transaction (last R beat or B handshake).
- outstanding_o  out  CNT_WIDTH  current in-flight count.
- full_o  out  1  outstanding_o == MAX_TXNS.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is asynchronous, active-high.
- Reset values: out_valid_o=0, out_id_o/out_addr_o/out_len_o=0, outstanding_o=0, full_o=0, priority pointer=0.
- Output stage: one register slot.
  - slot_free = !out_valid_o || out_ready_i.
  - can_accept = slot_free && (outstanding_o < MAX_TXNS).
  - No combinational path from rsp_done_i to any ready.
- Arbitration (combinational, each cycle):
  - Search in_valid_i starting at the pointer, wrapping modulo NUM_REQ.
  - The first valid requester k is the candidate.
  - in_ready_o[k] = can_accept. All other in_ready_o bits are 0.
  - No candidate: in_ready_o is all zeros.
- Accept (in_valid_i[k] && in_ready_o[k]):
  - Next cycle out_valid_o=1, out_id_o={k, id_k}, and out_addr_o/out_len_o carry requester k's fields.
  - Pointer becomes (k+1) mod NUM_REQ.
  - Latency is exactly 1 cycle. Back-to-back accepts run at one per cycle while out_ready_i=1.
- No accept while out_valid_o && out_ready_i: out_valid_o goes to 0 next cycle.
- No accept and slot not draining: out payload and out_valid_o hold. Payload is stable while valid && !ready (AXI rule).
- Pointer changes only on accept. A stalled requester keeps priority until served, so there is no starvation.
- Counter:
  - inc = accept, dec = rsp_done_i && outstanding_o != 0.
  - inc && dec: count unchanged.
  - inc alone: +1. dec alone: -1.
  - The count is incremented at accept, so it includes the request held in the output slot.
- rsp_done_i with count 0: ignored (count stays 0). Simulation-only assertion fires.
- At count == MAX_TXNS all in_ready_o are 0, even if rsp_done_i is high that cycle. Acceptance resumes the cycle after the decrement.
- Requester protocol: requesters must hold valid and payload until ready. Simulation-only assertion checks each in_valid_i for stability.
- Reset mid-operation: output slot dropped, pointer 0, count 0 immediately. No handshake completes during reset.

Test Plan:
- Single request: req 2 valid, id=3, addr=0x1000, len=7 → in_ready_o=4'b0100 the same cycle; next cycle out_valid_o=1, out_id_o={2'd2,4'd3}, addr 0x1000, len 7; outstanding_o=1.
- Fairness: all 4 requesters continuously valid, out_ready_i=1 → grant order 0,1,2,3,0,1… at one per cycle; after 8 accepts with no rsp_done_i, full_o=1 and all readies 0.
- Backpressure: out_ready_i=0 for 5 cycles with out_valid_o=1 → payload constant, no new accepts; when out_ready_i=1, the next grant is accepted the same cycle (zero bubble).
- Limit recovery: outstanding_o=8, rsp_done_i pulse → no accept that cycle; outstanding_o=7 next cycle, accept allowed, outstanding_o returns to 8.
- Simultaneous inc/dec: outstanding_o=3, accept and rsp_done_i in the same cycle → stays 3. rsp_done_i at count 0 → stays 0 and the assertion is flagged.
- Async reset: rst_i asserted mid-cycle while out_valid_o=1 and outstanding_o=5 → out_valid_o=0 and outstanding_o=0 before the next clock edge; after release, the first grant goes to requester 0.
